// File: rtl/afe_seq_ctl.sv
// AFE line sequencer: drives the IRST/STI -> readout clock -> SHR -> INTG -> SHS
// cycle for a daisy-chain of analog front-ends. It supports single-frame and
// continuous operation, a start/stop handshake, line/frame status and an STO
// chain-integrity flag. Every output is registered from the next-state values,
// so the pins line up exactly with the phase they belong to.
module afe_seq_ctl #(
  parameter int N_CH        = 64,
  parameter int N_AFE       = 1,
  parameter int CLK_EXTRA   = 3,
  parameter int CLK_HALF    = 65,
  parameter int T_IRST      = 100,
  parameter int T_SXX       = 50,
  parameter int T_WAIT_INTG = 100,
  parameter int T_WAIT_SHS  = 500,
  parameter int T_END       = 10,
  parameter int T_DF_LEAD   = 50,
  parameter int DF_EN       = 1,
  parameter int CW          = 16
) (
  input  logic          CLK_100M,
  input  logic          CLK_RST,
  input  logic          ADS_INIT_OK,
  input  logic          start,
  input  logic          stop,
  input  logic          cont_mode,
  input  logic [15:0]   num_lines,
  input  logic [CW-1:0] intg_cycles,
  input  logic [2:0]    pga_sel,
  input  logic          AFE_STO,
  output logic          AFE_CLK,
  output logic          AFE_INTG,
  output logic          AFE_IRST,
  output logic          AFE_SHS,
  output logic          AFE_SHR,
  output logic          AFE_STI,
  output logic          AFE_DF_SM,
  output logic [2:0]    AFE_PGA,
  output logic          busy,
  output logic          line_start,
  output logic          line_done,
  output logic          frame_done,
  output logic [15:0]   line_cnt,
  output logic          sto_err
);

  localparam int NCLK    = N_AFE * N_CH + CLK_EXTRA;
  localparam int RD_LEN  = 2 * CLK_HALF * NCLK;
  localparam int M1      = (T_IRST > T_WAIT_INTG) ? T_IRST : T_WAIT_INTG;
  localparam int M2      = (M1 > T_SXX + T_END) ? M1 : T_SXX + T_END;
  localparam int FIX_MAX = (M2 > RD_LEN) ? M2 : RD_LEN;
  localparam int FIX_W   = $clog2(FIX_MAX + 1);
  // The INTG phase can reach (2^CW - 1) + T_WAIT_SHS, hence at least CW+1 bits.
  localparam int CNT_W   = (FIX_W > CW + 1) ? FIX_W : CW + 1;
  localparam int HW      = $clog2(CLK_HALF);

  localparam logic [CNT_W-1:0] IRST_LAST = CNT_W'(T_IRST - 1);
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_LEN - 1);
  localparam logic [CNT_W-1:0] SHR_LAST  = CNT_W'(T_WAIT_INTG - 1);
  localparam logic [CNT_W-1:0] SHS_LAST  = CNT_W'(T_SXX + T_END - 1);
  localparam logic [CNT_W-1:0] SXX       = CNT_W'(T_SXX);
  localparam logic [CNT_W-1:0] WAIT_SHS  = CNT_W'(T_WAIT_SHS);
  localparam logic [CNT_W-1:0] DF_LEAD   = CNT_W'(T_DF_LEAD);
  localparam logic [HW-1:0]    HALF_LAST = HW'(CLK_HALF - 1);

  typedef enum logic [2:0] {S_IDLE, S_IRST, S_RDOUT, S_SHR, S_INTG, S_SHS} state_t;

  state_t           state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [CW-1:0]    intg_l, intg_use;
  logic [CNT_W-1:0] intg_ext;
  logic [15:0]      nlines_l;
  logic             cont_l;
  logic             stop_pend;
  logic             sto_seen;
  logic [HW-1:0]    hcnt;
  logic             start_go;
  logic             more_lines;
  logic             last_shs_nxt;

  function automatic logic [CW-1:0] clamp_intg(input logic [CW-1:0] v);
    return (v == '0) ? CW'(1) : v;
  endfunction

  function automatic logic [15:0] clamp_lines(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

  // Next-state and phase-counter logic
  always_comb begin
    nxt_state  = state;
    intg_use   = (state == S_INTG) ? intg_l : clamp_intg(intg_cycles);
    intg_ext   = CNT_W'(intg_use);
    start_go   = (state == S_IDLE) && start && ADS_INIT_OK;
    // line_cnt has already been bumped when the final SHS cycle is reached
    more_lines = !(stop_pend || stop) && (cont_l || (line_cnt < nlines_l));
    case (state)
      S_IDLE:  if (start_go) nxt_state = S_IRST;
      S_IRST:  if (cnt == IRST_LAST) nxt_state = S_RDOUT;
      S_RDOUT: if (cnt == RD_LAST) nxt_state = S_SHR;
      S_SHR:   if (cnt == SHR_LAST) nxt_state = S_INTG;
      S_INTG:  if (cnt == intg_ext + WAIT_SHS - CNT_W'(1)) nxt_state = S_SHS;
      S_SHS:   if (cnt == SHS_LAST) nxt_state = more_lines ? S_IRST : S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
    nxt_cnt      = (nxt_state != state || nxt_state == S_IDLE) ? '0 : cnt + 1'b1;
    last_shs_nxt = (nxt_state == S_SHS) && (nxt_cnt == SHS_LAST);
  end

  // State register and phase counter
  always_ff @(posedge CLK_100M or posedge CLK_RST) begin
    if (CLK_RST) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
    end
  end

  // Frame parameters captured at start / INTG entry (data only, no reset needed)
  always_ff @(posedge CLK_100M) begin
    if (start_go) nlines_l <= clamp_lines(num_lines);
    if (nxt_state == S_INTG) intg_l <= intg_use;
  end

  // Frame control and status: mode latch, stop request, STO tracking, counters
  always_ff @(posedge CLK_100M or posedge CLK_RST) begin
    if (CLK_RST) begin
      cont_l     <= 1'b0;
      stop_pend  <= 1'b0;
      sto_seen   <= 1'b0;
      sto_err    <= 1'b0;
      line_cnt   <= '0;
      AFE_PGA    <= 3'b111;
      busy       <= 1'b0;
      line_start <= 1'b0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (start_go) begin
        cont_l    <= cont_mode;
        AFE_PGA   <= pga_sel;
        stop_pend <= stop;
        sto_seen  <= 1'b0;
        sto_err   <= 1'b0;
        line_cnt  <= '0;
      end else begin
        if (state != S_IDLE) begin
          if (nxt_state == S_IDLE) stop_pend <= 1'b0;
          else if (stop)           stop_pend <= 1'b1;
        end
        if (last_shs_nxt) begin
          line_cnt <= line_cnt + 16'd1;
          sto_seen <= 1'b0;
          if (!sto_seen) sto_err <= 1'b1;
        end else if (state == S_RDOUT && AFE_STO) begin
          sto_seen <= 1'b1;
        end
      end
      busy       <= (nxt_state != S_IDLE);
      line_start <= (nxt_state == S_RDOUT) && (state != S_RDOUT);
      line_done  <= last_shs_nxt;
      frame_done <= (state != S_IDLE) && (nxt_state == S_IDLE);
    end
  end

  // AFE pin drive: phase strobes, readout clock and DF_SM window
  always_ff @(posedge CLK_100M or posedge CLK_RST) begin
    if (CLK_RST) begin
      AFE_CLK   <= 1'b0;
      hcnt      <= '0;
      AFE_IRST  <= 1'b0;
      AFE_STI   <= 1'b0;
      AFE_SHR   <= 1'b0;
      AFE_INTG  <= 1'b0;
      AFE_SHS   <= 1'b0;
      AFE_DF_SM <= 1'b1;
    end else begin
      if (nxt_state == S_RDOUT) begin
        if (state != S_RDOUT) begin
          AFE_CLK <= 1'b1;
          hcnt    <= '0;
        end else if (hcnt == HALF_LAST) begin
          AFE_CLK <= ~AFE_CLK;
          hcnt    <= '0;
        end else begin
          hcnt <= hcnt + 1'b1;
        end
      end else begin
        AFE_CLK <= 1'b0;
        hcnt    <= '0;
      end
      AFE_IRST  <= (nxt_state == S_IRST);
      AFE_STI   <= (nxt_state == S_IRST) && (nxt_cnt < SXX);
      AFE_SHR   <= (nxt_state == S_SHR)  && (nxt_cnt < SXX);
      AFE_SHS   <= (nxt_state == S_SHS)  && (nxt_cnt < SXX);
      AFE_INTG  <= (nxt_state == S_INTG) && (nxt_cnt < intg_ext);
      // DF_SM goes low at INTG entry and returns high T_DF_LEAD before INTG falls
      AFE_DF_SM <= !((DF_EN != 0) && (nxt_state == S_INTG) &&
                     (({1'b0, nxt_cnt} + {1'b0, DF_LEAD}) < {1'b0, intg_ext}));
    end
  end

endmodule
